// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared defaults for the write-back arbiter slice
package regfile_wb_arbiter_pkg;

  localparam int NREQ_DEFAULT   = 3;
  localparam int DATA_W_DEFAULT = 32;
  localparam int ADDR_W_DEFAULT = 5;

  // Register 0 is hardwired: writes are swallowed and it is never pending.
  localparam int ZERO_REG = 0;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rtl/regfile_wb_arbiter_rr_arbiter.sv - round-robin grant starting at ptr
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  localparam logic [IW:0] N_W = (IW + 1)'(N);

  logic [IW:0] idx;
  logic        found;

  // ptr < N, so ptr + i stays below 2N and one conditional subtract wraps it.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, ptr} + (IW + 1)'(i);
      if (idx >= N_W) idx = idx - N_W;
      if (!found && req[idx[IW-1:0]]) begin
        found                = 1'b1;
        grant[idx[IW-1:0]]   = 1'b1;
        grant_idx            = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - write-back arbiter with pending-write scoreboard
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREQ   = NREQ_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          ReqValid,
  input  logic [NREQ*ADDR_W-1:0]   ReqAddr,
  input  logic [NREQ*DATA_W-1:0]   ReqData,
  output logic [NREQ-1:0]          ReqReady,
  input  logic                     ResValid,
  input  logic [ADDR_W-1:0]        ResAddr,
  input  logic [ADDR_W-1:0]        ChkAddr1,
  input  logic [ADDR_W-1:0]        ChkAddr2,
  output logic                     Busy1,
  output logic                     Busy2,
  output logic                     RegWrite,
  output logic [ADDR_W-1:0]        WriteAddr,
  output logic [DATA_W-1:0]        WriteData
);

  localparam int                IW        = idx_width(NREQ);
  localparam int                NREG      = 1 << ADDR_W;
  localparam logic [IW-1:0]     PTR_LAST  = IW'(NREQ - 1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [IW-1:0]     ptr;
  logic [NREQ-1:0]   grant;
  logic [IW-1:0]     grant_idx;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [NREG-1:0]   pending;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr_arbiter (
    .req       (ReqValid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign ReqReady = grant;
  assign accept   = |grant;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        sel_addr = ReqAddr[k*ADDR_W +: ADDR_W];
        sel_data = ReqData[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (grant_idx == PTR_LAST) ? '0 : grant_idx + 1'b1;
    end
  end

  // Reservation is applied after the clear so a same-edge set wins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
    end else begin
      if (accept) pending[sel_addr] <= 1'b0;
      if (ResValid && ResAddr != ZERO_ADDR) pending[ResAddr] <= 1'b1;
    end
  end

  assign Busy1 = pending[ChkAddr1];
  assign Busy2 = pending[ChkAddr2];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      RegWrite  <= 1'b0;
      WriteAddr <= '0;
      WriteData <= '0;
    end else begin
      RegWrite <= accept && (sel_addr != ZERO_ADDR);
      if (accept) begin
        WriteAddr <= sel_addr;
        WriteData <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  localparam int NREQ   = 3;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct {
    int                due;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic                   clock = 1'b0;
  logic                   reset_n;
  logic [NREQ-1:0]        ReqValid;
  logic [NREQ*ADDR_W-1:0] ReqAddr;
  logic [NREQ*DATA_W-1:0] ReqData;
  logic [NREQ-1:0]        ReqReady;
  logic                   ResValid;
  logic [ADDR_W-1:0]      ResAddr;
  logic [ADDR_W-1:0]      ChkAddr1;
  logic [ADDR_W-1:0]      ChkAddr2;
  logic                   Busy1;
  logic                   Busy2;
  logic                   RegWrite;
  logic [ADDR_W-1:0]      WriteAddr;
  logic [DATA_W-1:0]      WriteData;

  int  checks = 0;
  int  errors = 0;
  int  cycle  = 0;
  wr_t exp_q[$];

  regfile_wb_arbiter #(
    .NREQ   (NREQ),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .ReqValid  (ReqValid),
    .ReqAddr   (ReqAddr),
    .ReqData   (ReqData),
    .ReqReady  (ReqReady),
    .ResValid  (ResValid),
    .ResAddr   (ResAddr),
    .ChkAddr1  (ChkAddr1),
    .ChkAddr2  (ChkAddr2),
    .Busy1     (Busy1),
    .Busy2     (Busy2),
    .RegWrite  (RegWrite),
    .WriteAddr (WriteAddr),
    .WriteData (WriteData)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: every negedge, a write either matches the queue head or is flagged.
  always @(negedge clock) begin
    wr_t e;
    if (RegWrite === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write (cycle %0d)",
                 WriteAddr, WriteData, cycle);
      end else begin
        e = exp_q.pop_front();
        if (e.due != cycle || WriteAddr !== e.addr || WriteData !== e.data) begin
          errors++;
          $display("FAIL write: got cycle %0d addr %0h data %0h expected cycle %0d addr %0h data %0h",
                   cycle, WriteAddr, WriteData, e.due, e.addr, e.data);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cycle) begin
      checks++;
      errors++;
      e = exp_q.pop_front();
      $display("FAIL missing_write: got RegWrite %0b expected write addr %0h data %0h at cycle %0d",
               RegWrite, e.addr, e.data, e.due);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int k, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ReqAddr[k*ADDR_W +: ADDR_W] = a;
    ReqData[k*DATA_W +: DATA_W] = d;
  endtask

  task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_t e;
    e.due  = cycle + 1;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    reset_n  = 1'b0;
    ReqValid = '0;
    ReqAddr  = '0;
    ReqData  = '0;
    ResValid = 1'b0;
    ResAddr  = '0;
    ChkAddr1 = '0;
    ChkAddr2 = '0;
    tick();
    tick();

    // Reset state; ready is still combinational from ReqValid with ptr 0
    ReqValid = 3'b111;
    ChkAddr1 = 5'd1;
    #1;
    check("reset_regwrite", {31'd0, RegWrite}, 32'd0);
    check("reset_waddr", {27'd0, WriteAddr}, 32'd0);
    check("reset_wdata", WriteData, 32'd0);
    check("reset_busy1", {31'd0, Busy1}, 32'd0);
    check("reset_ready", {29'd0, ReqReady}, 32'd1);
    ReqValid = '0;
    tick();
    reset_n = 1'b1;

    // All three requesting for four cycles: grants 0,1,2,0
    set_req(0, 5'd1, 32'hA0A0_0001);
    set_req(1, 5'd2, 32'hA1A1_0002);
    set_req(2, 5'd3, 32'hA2A2_0003);
    ReqValid = 3'b111;
    #1; check("rr_grant0", {29'd0, ReqReady}, 32'b001); expect_write(5'd1, 32'hA0A0_0001); tick();
    check("rr_grant1", {29'd0, ReqReady}, 32'b010); expect_write(5'd2, 32'hA1A1_0002); tick();
    check("rr_grant2", {29'd0, ReqReady}, 32'b100); expect_write(5'd3, 32'hA2A2_0003); tick();
    check("rr_grant0_wrap", {29'd0, ReqReady}, 32'b001); expect_write(5'd1, 32'hA0A0_0001); tick();

    // Single requester 1 with ptr at 1
    ReqValid = 3'b010;
    set_req(1, 5'd7, 32'hDEAD_BEEF);
    #1; check("single_grant1", {29'd0, ReqReady}, 32'b010); expect_write(5'd7, 32'hDEAD_BEEF); tick();
    ReqValid = '0;
    #1; check("idle_ready", {29'd0, ReqReady}, 32'd0); tick();
    check("idle_regwrite", {31'd0, RegWrite}, 32'd0);

    // Reserve 9, then retire it via requester 2 (ptr now 2)
    ResValid = 1'b1; ResAddr = 5'd9; tick();
    ResValid = 1'b0; ChkAddr1 = 5'd9;
    #1; check("busy_set_9", {31'd0, Busy1}, 32'd1);
    ReqValid = 3'b100; set_req(2, 5'd9, 32'h0000_0909);
    #1; check("grant2_addr9", {29'd0, ReqReady}, 32'b100);
    check("busy_hold_9", {31'd0, Busy1}, 32'd1);
    expect_write(5'd9, 32'h0000_0909); tick();
    ReqValid = '0;
    #1; check("busy_clear_9", {31'd0, Busy1}, 32'd0);
    check("no_forward_addr", {27'd0, WriteAddr}, 32'd9);
    tick();

    // Reserve 4, then reserve again on the same edge its write retires (ptr 0)
    ResValid = 1'b1; ResAddr = 5'd4; tick();
    ReqValid = 3'b001; set_req(0, 5'd4, 32'h0000_0444);
    #1; check("grant0_addr4", {29'd0, ReqReady}, 32'b001);
    expect_write(5'd4, 32'h0000_0444); tick();
    ResValid = 1'b0; ReqValid = '0; ChkAddr2 = 5'd4;
    #1; check("set_wins_4", {31'd0, Busy2}, 32'd1);
    tick();

    // Write to register 0 is consumed without RegWrite (ptr 1)
    ReqValid = 3'b010; set_req(1, 5'd0, 32'hFFFF_FFFF);
    #1; check("zero_ready", {29'd0, ReqReady}, 32'b010); tick();
    ReqValid = '0;
    #1; check("zero_no_write", {31'd0, RegWrite}, 32'd0);
    ResValid = 1'b1; ResAddr = 5'd0; ChkAddr1 = 5'd0; tick();
    ResValid = 1'b0;
    #1; check("zero_not_busy", {31'd0, Busy1}, 32'd0);

    // Reset mid-write with register 3 pending (ptr 2)
    ResValid = 1'b1; ResAddr = 5'd3; tick();
    ResValid = 1'b0; ChkAddr1 = 5'd3;
    ReqValid = 3'b100; set_req(2, 5'd5, 32'h5555_AAAA);
    #1; check("busy_set_3", {31'd0, Busy1}, 32'd1);
    check("grant2_addr5", {29'd0, ReqReady}, 32'b100);
    expect_write(5'd5, 32'h5555_AAAA); tick();
    ReqValid = '0;
    #1; check("pre_reset_regwrite", {31'd0, RegWrite}, 32'd1);
    @(negedge clock); #1;
    reset_n = 1'b0;
    #1;
    check("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    check("rst_busy3", {31'd0, Busy1}, 32'd0);
    tick();
    reset_n = 1'b1;
    ReqValid = 3'b111;
    set_req(0, 5'd6, 32'h6666_0000);
    #1; check("post_reset_grant0", {29'd0, ReqReady}, 32'b001);
    expect_write(5'd6, 32'h6666_0000); tick();
    ReqValid = '0;
    tick();
    tick();

    check("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
